// File: rtl/rob_if.sv
// Reorder buffer interface.
// Bundles the decode (reserve), execution (write) and commit (consume)
// channels of the reorder buffer. The master side drives requests and
// results. The slave side is the buffer itself.
//   reserve / reserve_count        : reservation request, count minus 1
//   reserved_slots                 : slot indices the next reservation gets
//   write_slot/valid/data          : per-port result writes
//   consume / consume_count        : retire request, count minus 1
//   slot_data / slot_valid         : oldest EXT_COUNT entries in program order
//   empty / full                   : occupancy status
interface rob_if #(
  parameter type T         = logic [31:0],
  parameter int  DEPTH     = 16,
  parameter int  INS_COUNT = 4,
  parameter int  EXT_COUNT = 4,
  parameter int  WR_COUNT  = 4
);
  localparam int SW  = $clog2(DEPTH);
  localparam int ICW = $clog2(INS_COUNT);
  localparam int ECW = $clog2(EXT_COUNT);

  logic                           reserve;
  logic [ICW-1:0]                 reserve_count;
  logic [INS_COUNT-1:0][SW-1:0]   reserved_slots;
  logic [WR_COUNT-1:0][SW-1:0]    write_slot;
  logic [WR_COUNT-1:0]            write_valid;
  T     [WR_COUNT-1:0]            write_data;
  logic                           consume;
  logic [ECW-1:0]                 consume_count;
  T     [EXT_COUNT-1:0]           slot_data;
  logic [EXT_COUNT-1:0]           slot_valid;
  logic                           empty;
  logic                           full;

  modport master (
    output reserve, reserve_count, write_slot, write_valid, write_data,
           consume, consume_count,
    input  reserved_slots, slot_data, slot_valid, empty, full
  );

  modport slave (
    input  reserve, reserve_count, write_slot, write_valid, write_data,
           consume, consume_count,
    output reserved_slots, slot_data, slot_valid, empty, full
  );
endinterface

// File: rtl/rob.sv
// Circular reorder buffer.
// Decode reserves up to INS_COUNT consecutive slots per cycle. Execution
// units write results into reserved slots out of order. Commit sees the
// EXT_COUNT oldest entries and retires a fully-written contiguous prefix.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears all state and data
//   bus     : rob_if slave modport (reserve / write / consume channels)
module rob #(
  parameter type T         = logic [31:0],
  parameter int  DEPTH     = 16,
  parameter int  INS_COUNT = 4,
  parameter int  EXT_COUNT = 4,
  parameter int  WR_COUNT  = 4
) (
  input logic   clock,
  input logic   reset_n,
  rob_if.slave  bus
);
  localparam int SW = $clog2(DEPTH);
  localparam int CW = SW + 1;

  logic [SW-1:0]                ins_ptr, ins_ptr_d;
  logic [SW-1:0]                ext_ptr, ext_ptr_d;
  logic [CW-1:0]                used_count, used_count_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  T     [DEPTH-1:0]             data_q, data_d;

  logic [EXT_COUNT-1:0][SW-1:0] ext_idx;
  logic [EXT_COUNT-1:0]         slot_valid_c;
  logic [CW-1:0]                res_n, con_m;
  logic                         full_c;
  logic                         prefix_ok;
  logic                         do_reserve, do_consume;

  assign full_c         = used_count > CW'(DEPTH - INS_COUNT);
  assign bus.full       = full_c;
  assign bus.empty      = (used_count == '0);
  assign bus.slot_valid = slot_valid_c;

  always_comb begin
    for (int i = 0; i < INS_COUNT; i++) begin
      bus.reserved_slots[i] = ins_ptr + SW'(i);
    end
  end

  // Entries beyond used_count may still hold stale valid bits from a
  // previous lap, so validity is qualified by occupancy.
  always_comb begin
    for (int i = 0; i < EXT_COUNT; i++) begin
      ext_idx[i] = ext_ptr + SW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < EXT_COUNT; i++) begin
      bus.slot_data[i] = data_q[ext_idx[i]];
      slot_valid_c[i]  = valid_q[ext_idx[i]] && (CW'(i) < used_count);
    end
  end

  // A retire is accepted only when every requested entry is written.
  always_comb begin
    prefix_ok = 1'b1;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (i <= int'(bus.consume_count) && !slot_valid_c[i]) begin
        prefix_ok = 1'b0;
      end
    end
  end

  assign res_n      = CW'(bus.reserve_count) + CW'(1);
  assign con_m      = CW'(bus.consume_count) + CW'(1);
  assign do_reserve = bus.reserve && !full_c;
  assign do_consume = bus.consume && prefix_ok;

  // Next-state: reservation clears, then writes (higher port overrides
  // lower), then retirement clears. Retirement was decided on pre-edge state.
  always_comb begin
    ins_ptr_d    = ins_ptr;
    ext_ptr_d    = ext_ptr;
    used_count_d = used_count;
    valid_d      = valid_q;
    data_d       = data_q;

    if (do_reserve) begin
      ins_ptr_d = ins_ptr + res_n[SW-1:0];
      for (int j = 0; j < INS_COUNT; j++) begin
        if (j <= int'(bus.reserve_count)) begin
          valid_d[ins_ptr + SW'(j)] = 1'b0;
        end
      end
    end

    for (int p = 0; p < WR_COUNT; p++) begin
      if (bus.write_valid[p]) begin
        data_d[bus.write_slot[p]]  = bus.write_data[p];
        valid_d[bus.write_slot[p]] = 1'b1;
      end
    end

    if (do_consume) begin
      ext_ptr_d = ext_ptr + con_m[SW-1:0];
      for (int j = 0; j < EXT_COUNT; j++) begin
        if (j <= int'(bus.consume_count)) begin
          valid_d[ext_ptr + SW'(j)] = 1'b0;
        end
      end
    end

    used_count_d = used_count
                 + (do_reserve ? res_n : CW'(0))
                 - (do_consume ? con_m : CW'(0));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ins_ptr    <= '0;
      ext_ptr    <= '0;
      used_count <= '0;
      valid_q    <= '0;
      data_q     <= '0;
    end else begin
      ins_ptr    <= ins_ptr_d;
      ext_ptr    <= ext_ptr_d;
      used_count <= used_count_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end
endmodule

// File: tb/tb_rob.sv
// Testbench for the reorder buffer.
// Directed scenarios check reset, reservation, out-of-order writes, the
// all-written retire rule, the full limit, asynchronous reset and same-edge
// reserve/consume. A randomized stream is checked against a program-order
// queue model: committed data must come out as 0, 1, 2, ... across wraps.
module tb_rob;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    int seq;
    bit written;
  } entry_t;

  rob_if bus ();

  rob dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Returns all request inputs to idle.
  task automatic clearInputs();
    bus.reserve       = 1'b0;
    bus.reserve_count = '0;
    bus.write_valid   = '0;
    bus.write_slot    = '0;
    bus.write_data    = '0;
    bus.consume       = 1'b0;
    bus.consume_count = '0;
  endtask

  // Advances one clock; leaves time just after the edge with idle inputs.
  task automatic stepCycle();
    @(posedge clock);
    #1;
    clearInputs();
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.empty, bus.full, dut.used_count} !== {1'b1, 1'b0, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got empty=%0b full=%0b used=%0d want 1 0 0",
               bus.empty, bus.full, dut.used_count);
    end
    vectors++;
    if (bus.reserved_slots !== {4'd3, 4'd2, 4'd1, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_slots: got %h want 3210", bus.reserved_slots);
    end
    vectors++;
    if (bus.slot_valid !== 4'b0000 || bus.slot_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ext: got valid=%b data=%h want 0 0",
               bus.slot_valid, bus.slot_data);
    end
  endtask

  task automatic test_basic();
    bus.reserve = 1'b1;
    bus.reserve_count = 2'd3;
    stepCycle();
    vectors++;
    if ({dut.ins_ptr, dut.used_count, bus.empty, bus.slot_valid} !== {4'd4, 5'd4, 1'b0, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL reserve4: got ins=%0d used=%0d empty=%0b valid=%b want 4 4 0 0000",
               dut.ins_ptr, dut.used_count, bus.empty, bus.slot_valid);
    end
    vectors++;
    if (bus.reserved_slots !== {4'd7, 4'd6, 4'd5, 4'd4}) begin
      miscompares++;
      $display("[TB] FAIL reserve4_slots: got %h want 7654", bus.reserved_slots);
    end

    bus.write_valid = 4'b0011;
    bus.write_slot[0] = 4'd1;  bus.write_data[0] = 32'hB;
    bus.write_slot[1] = 4'd3;  bus.write_data[1] = 32'hD;
    stepCycle();
    vectors++;
    if (bus.slot_valid !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL partial_valid: got %b want 1010", bus.slot_valid);
    end

    // Oldest entry is unwritten, so a single retire must be refused.
    bus.consume = 1'b1;
    bus.consume_count = 2'd0;
    stepCycle();
    vectors++;
    if ({dut.used_count, dut.ext_ptr} !== {5'd4, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL consume_ignored: got used=%0d ext=%0d want 4 0",
               dut.used_count, dut.ext_ptr);
    end

    // Ports 0 and 2 both hit slot 0; port 2 must win.
    bus.write_valid = 4'b0111;
    bus.write_slot[0] = 4'd0;  bus.write_data[0] = 32'h1;
    bus.write_slot[1] = 4'd2;  bus.write_data[1] = 32'hC;
    bus.write_slot[2] = 4'd0;  bus.write_data[2] = 32'hA;
    stepCycle();
    vectors++;
    if (bus.slot_valid !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL all_valid: got %b want 1111", bus.slot_valid);
    end
    vectors++;
    if (bus.slot_data !== {32'hD, 32'hC, 32'hB, 32'hA}) begin
      miscompares++;
      $display("[TB] FAIL order_data: got %h want D C B A", bus.slot_data);
    end

    bus.consume = 1'b1;
    bus.consume_count = 2'd3;
    stepCycle();
    vectors++;
    if ({dut.used_count, dut.ext_ptr, bus.empty, bus.slot_valid} !== {5'd0, 4'd4, 1'b1, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL consume4: got used=%0d ext=%0d empty=%0b valid=%b want 0 4 1 0000",
               dut.used_count, dut.ext_ptr, bus.empty, bus.slot_valid);
    end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) begin
      bus.reserve = 1'b1;
      bus.reserve_count = 2'd3;
      stepCycle();
      vectors++;
      if ({dut.used_count, bus.full} !== {5'(4 * k), (4 * k > 12)}) begin
        miscompares++;
        $display("[TB] FAIL fill_%0d: got used=%0d full=%0b want %0d %0b",
                 k, dut.used_count, bus.full, 4 * k, (4 * k > 12));
      end
    end
    bus.reserve = 1'b1;
    bus.reserve_count = 2'd0;
    stepCycle();
    vectors++;
    if ({dut.ins_ptr, dut.used_count, bus.full, bus.slot_valid} !== {4'd4, 5'd16, 1'b1, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL reserve_when_full: got ins=%0d used=%0d full=%0b valid=%b want 4 16 1 0000",
               dut.ins_ptr, dut.used_count, bus.full, bus.slot_valid);
    end
  endtask

  task automatic test_reset_mid();
    // Slots 0..3 still hold A..D from earlier; reset must wipe them at once.
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({dut.ins_ptr, dut.used_count, bus.empty, bus.full} !== {4'd0, 5'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_state: got ins=%0d used=%0d empty=%0b full=%0b want 0 0 1 0",
               dut.ins_ptr, dut.used_count, bus.empty, bus.full);
    end
    vectors++;
    if (bus.slot_data !== '0 || bus.reserved_slots !== {4'd3, 4'd2, 4'd1, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_data: got data=%h slots=%h want 0 3210",
               bus.slot_data, bus.reserved_slots);
    end
    #2;
    reset_n = 1'b1;
    stepCycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      bus.reserve = 1'b1;
      bus.reserve_count = 2'd3;
      stepCycle();
    end
    bus.write_valid = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      bus.write_slot[p] = 4'(p);
      bus.write_data[p] = 32'h100 + 32'(p);
    end
    stepCycle();
    vectors++;
    if ({dut.used_count, bus.slot_valid} !== {5'd8, 4'b1111}) begin
      miscompares++;
      $display("[TB] FAIL b2b_setup: got used=%0d valid=%b want 8 1111",
               dut.used_count, bus.slot_valid);
    end
    bus.reserve = 1'b1;
    bus.reserve_count = 2'd1;
    bus.consume = 1'b1;
    bus.consume_count = 2'd2;
    stepCycle();
    vectors++;
    if ({dut.used_count, dut.ins_ptr, dut.ext_ptr} !== {5'd7, 4'd10, 4'd3}) begin
      miscompares++;
      $display("[TB] FAIL b2b_ptrs: got used=%0d ins=%0d ext=%0d want 7 10 3",
               dut.used_count, dut.ins_ptr, dut.ext_ptr);
    end
    vectors++;
    if (bus.slot_valid !== 4'b0001 || bus.slot_data[0] !== 32'h103 ||
        bus.reserved_slots !== {4'd13, 4'd12, 4'd11, 4'd10}) begin
      miscompares++;
      $display("[TB] FAIL b2b_outputs: got valid=%b data0=%h slots=%h want 0001 103 dcba",
               bus.slot_valid, bus.slot_data[0], bus.reserved_slots);
    end
  endtask

  task automatic test_random_stream();
    entry_t occ[$];
    int resTotal = 0;
    int retTotal = 0;
    int nextCommit = 0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    stepCycle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int n, m, k, u;
      bit resAcc, conAcc;
      int tgt[4];
      logic [3:0] expValid;
      logic [3:0][3:0] expSlots;

      clearInputs();
      bus.reserve       = ($urandom_range(0, 3) != 0);
      bus.reserve_count = 2'($urandom_range(0, 3));
      n      = int'(bus.reserve_count) + 1;
      resAcc = bus.reserve && (occ.size() <= DEPTH - 4);

      for (int p = 0; p < 4; p++) begin
        tgt[p] = -1;
        if (occ.size() > 0 && $urandom_range(0, 2) != 0) begin
          u = int'($urandom_range(0, occ.size() - 1));
          if (!occ[u].written) tgt[p] = u;
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (tgt[p] >= 0) begin
          bus.write_valid[p] = 1'b1;
          bus.write_slot[p]  = 4'((retTotal + tgt[p]) % DEPTH);
          bus.write_data[p]  = 32'(occ[tgt[p]].seq);
          // A higher port targeting the same slot must override this one.
          for (int q = p + 1; q < 4; q++) begin
            if (tgt[q] == tgt[p]) bus.write_data[p] = 32'hDEAD_0000 | 32'(p);
          end
        end
      end

      k = 0;
      while (k < occ.size() && occ[k].written) k++;
      m = int'($urandom_range(1, 4));
      bus.consume       = 1'($urandom_range(0, 1));
      bus.consume_count = 2'(m - 1);
      conAcc = bus.consume && (m <= k);
      #1;

      for (int i = 0; i < 4; i++) begin
        expValid[i] = (i < occ.size()) && occ[i].written;
        expSlots[i] = 4'((resTotal + i) % DEPTH);
      end
      vectors++;
      if (bus.slot_valid !== expValid) begin
        miscompares++;
        $display("[TB] FAIL rnd_valid cyc=%0d: got %b want %b", cyc, bus.slot_valid, expValid);
      end
      vectors++;
      if ({bus.empty, bus.full, dut.used_count} !== {occ.size() == 0, occ.size() > DEPTH - 4, 5'(occ.size())}) begin
        miscompares++;
        $display("[TB] FAIL rnd_status cyc=%0d: got empty=%0b full=%0b used=%0d want used=%0d",
                 cyc, bus.empty, bus.full, dut.used_count, occ.size());
      end
      vectors++;
      if (bus.reserved_slots !== expSlots) begin
        miscompares++;
        $display("[TB] FAIL rnd_slots cyc=%0d: got %h want %h", cyc, bus.reserved_slots, expSlots);
      end
      for (int i = 0; i < 4; i++) begin
        if (expValid[i]) begin
          vectors++;
          if (bus.slot_data[i] !== 32'(occ[i].seq)) begin
            miscompares++;
            $display("[TB] FAIL rnd_data cyc=%0d i=%0d: got %0d want %0d",
                     cyc, i, bus.slot_data[i], occ[i].seq);
          end
        end
      end
      if (conAcc) begin
        for (int j = 0; j < m; j++) begin
          vectors++;
          if (bus.slot_data[j] !== 32'(nextCommit + j)) begin
            miscompares++;
            $display("[TB] FAIL rnd_commit cyc=%0d: got %0d want %0d",
                     cyc, bus.slot_data[j], nextCommit + j);
          end
        end
      end

      @(posedge clock);
      #1;
      for (int p = 0; p < 4; p++) begin
        if (tgt[p] >= 0) occ[tgt[p]].written = 1'b1;
      end
      if (conAcc) begin
        for (int j = 0; j < m; j++) void'(occ.pop_front());
        retTotal   += m;
        nextCommit += m;
      end
      if (resAcc) begin
        for (int j = 0; j < n; j++) occ.push_back('{seq: resTotal + j, written: 1'b0});
        resTotal += n;
      end
    end
    clearInputs();
    vectors++;
    if (nextCommit < 100 || dut.ext_ptr !== 4'(retTotal % DEPTH)) begin
      miscompares++;
      $display("[TB] FAIL rnd_progress: got commits=%0d ext=%0d want >=100 and ext=%0d",
               nextCommit, dut.ext_ptr, retTotal % DEPTH);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clearInputs();
    #12;
    reset_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_full();
    test_reset_mid();
    test_back_to_back();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guards against a stalled simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Circular reorder buffer of DEPTH entries that keeps out-of-order results in program order.
- Decode reserves up to INS_COUNT consecutive slots per cycle and receives their slot indices.
- Execution units write results into arbitrary reserved slots (up to WR_COUNT per cycle).
- Commit sees up to EXT_COUNT oldest entries with per-entry valid flags and retires a contiguous prefix in order.

Parameters:
- T, 32-bit unsigned (integer unsigned): payload data type.
- DEPTH, 16: number of entries. Power of two; slot index width SW = log2(DEPTH) = 4.
- INS_COUNT, 4: maximum reservations per cycle.
- EXT_COUNT, 4: number of oldest entries presented to commit; maximum retirements per cycle.
- WR_COUNT, 4: number of result write ports.

Ports:
- clock  in  1  system clock, rising-edge active.
- reset_n  in  1  asynchronous, active-low reset.
- reserve  in  1  reserve request.
- reserve_count  in  log2(INS_COUNT)  number of slots to reserve minus 1.
- reserved_slots  out  INS_COUNT x SW  slot indices the next reservation will get.
- write_slot  in  WR_COUNT x SW  target slot for each write port.
- write_valid  in  WR_COUNT x 1  per-port write enable.
- write_data  in  WR_COUNT x T  per-port result data.
- consume  in  1  retire request.
- consume_count  in  log2(EXT_COUNT)  number of entries to retire minus 1.
- slot_data  out  EXT_COUNT x T  data of entry ext_ptr+i.
- slot_valid  out  EXT_COUNT x 1  entry ext_ptr+i is occupied and its result is written.
- empty  out  1  no entries occupied.
- full  out  1  a maximum-size reservation would not fit.

Behaviour:
- Internal state, all required as named signals for hierarchical debug access:
  - ins_ptr, SW bits: next slot to reserve.
  - ext_ptr, SW bits: oldest occupied slot.
  - used_count, SW+1 bits: 0..DEPTH.
  - per-entry valid bit and data register.
- Asynchronous reset (reset_n=0) clears ins_ptr, ext_ptr, used_count, all valid bits and all data to 0.
  - Resulting outputs: empty=1, full=0, slot_valid all 0, slot_data all 0, reserved_slots[i]=i.
  - Reset mid-operation discards all contents immediately.
- reserved_slots[i] = (ins_ptr + i) mod DEPTH. Combinational, valid every cycle whether or not reserve is high.
- Reserve: on a rising edge with reserve=1 and full=0, let n = reserve_count+1.
  - ins_ptr += n (mod DEPTH).
  - The n slots' valid bits are cleared.
  - used_count += n.
  - reserve while full=1 is ignored with no state change.
- Write: on a rising edge, for each port p with write_valid[p]=1:
  - data[write_slot[p]] <= write_data[p].
  - valid[write_slot[p]] <= 1.
  - Writes to distinct slots on the same edge all take effect.
  - Two ports targeting the same slot on one edge: the highest-numbered port wins.
  - Writes target only reserved, unretired slots (caller obligation); no checking is required.
- slot_data[i] = data[(ext_ptr+i) mod DEPTH], combinational.
- slot_valid[i] = valid[(ext_ptr+i) mod DEPTH] AND (i < used_count), combinational.
- Consume: on a rising edge with consume=1, let m = consume_count+1.
  - The request is accepted only if slot_valid[0..m-1] are all 1; otherwise it is ignored.
  - On acceptance: ext_ptr += m (mod DEPTH), used_count -= m, and the retired entries' valid bits are cleared.
- Simultaneous reserve and consume on the same edge: used_count += n - m. Each pointer advances independently.
- Simultaneous write and consume of the same slot: the consume decision uses the pre-edge valid state.
- Wrap-around: pointers wrap mod DEPTH, so slot indices run 15, 0, 1, ...
- Status flags, combinational from used_count:
  - empty = (used_count == 0).
  - full = (used_count > DEPTH - INS_COUNT), i.e. true when fewer than INS_COUNT free entries remain (used_count >= 13 with defaults).
- Latency: a write on edge k is visible on slot_valid/slot_data after edge k; it can be consumed at edge k+1 at the earliest.

Test Plan:
- Reset then idle -> empty=1, full=0, used_count=0, reserved_slots={0,1,2,3}, slot_valid all 0.
- Reserve 4 (reserve_count=3) -> ins_ptr=4, used_count=4, empty=0, reserved_slots={4,5,6,7}; slot_valid stays all 0.
- Write slots 1 and 3 with 0xB and 0xD -> slot_valid={0,1,0,1}. Consume with consume_count=0 is ignored (used_count stays 4). Then write slots 0 and 2 -> slot_valid all 1; consume_count=3 -> used_count=0, ext_ptr=4, empty=1, and slot_data before the edge read in program order.
- Reserve 4 four times with no consumes -> full=1 once used_count>=13; a further reserve is ignored (ins_ptr unchanged).
- Long run: reserve 4 per cycle, write results equal to a running sequence number in random order with random delay, consume all valid prefixes -> committed data is strictly 0, 1, 2, ... across pointer wrap (slot 15 -> 0).
- Same-edge reserve 2 + consume 3 with used_count=8 -> used_count=7; both pointers advance correctly.
